uart_tx: RTL and testbench

Serial UART transmitter, the transmit-side counterpart of the team's UART receiver, sharing the same runtime 32-bit baud divisor. It takes bytes over a valid/ready handshake into a one-entry holding register and serialises them as idle-high frames: start bit, data LSB first, optional parity bit, stop bit(s). The holding register allows back-to-back frames with no idle gap, so a bridge or CPU register block can stream bytes at full line rate.

---
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with a one-entry holding register; optional parity bit under UART_TX_PARITY_EN
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] baud_div,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_pin,
    output logic        tx_busy,
    output logic        tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]   hold_data_q, hold_data_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [31:0]            div_q, div_d;
    logic [31:0]            baud_cnt_q, baud_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   pin_q, pin_d;
    logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    logic        tick, last_data, last_stop, accept, load;
    logic [31:0] div_eff;
    logic        unused_tx_data;

    assign unused_tx_data = ^tx_data;
    assign tick      = (baud_cnt_q == 32'd0);
    assign last_data = (bit_cnt_q == LAST_DATA);
    assign last_stop = (bit_cnt_q == LAST_STOP);
    assign accept    = tx_valid && !hold_full_q;
    assign div_eff   = (baud_div == 32'd0) ? 32'd1 : baud_div;
    // A queued byte starts either from idle or straight out of the last stop bit.
    assign load      = hold_full_q &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && tick && last_stop));

    assign tx_ready = !hold_full_q;
    assign tx_pin   = pin_q;
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_done  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hold_full_q) state_d = S_START;
            S_START:  if (tick) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (tick && last_data) state_d = S_PARITY;
            S_PARITY: if (tick) state_d = S_STOP;
`else
            S_DATA:   if (tick && last_data) state_d = S_STOP;
`endif
            S_STOP:   if (tick && last_stop) state_d = hold_full_q ? S_START : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        shift_d     = shift_q;
        div_d       = div_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        pin_d       = pin_q;
        done_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        if (state_q != S_IDLE) baud_cnt_d = tick ? div_q - 32'd1 : baud_cnt_q - 32'd1;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data[DATA_BITS-1:0];
        end

        case (state_q)
            S_START: if (tick) begin
                pin_d     = shift_q[0];
                bit_cnt_d = 4'd0;
            end
            S_DATA: if (tick) begin
                if (last_data) begin
`ifdef UART_TX_PARITY_EN
                    pin_d = par_q;
`else
                    pin_d = 1'b1;
`endif
                    bit_cnt_d = 4'd0;
                end else begin
                    shift_d   = shift_q >> 1;
                    pin_d     = shift_q[1];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (tick) begin
                pin_d     = 1'b1;
                bit_cnt_d = 4'd0;
            end
`endif
            S_STOP: if (tick) begin
                if (last_stop) begin
                    done_d     = 1'b1;
                    baud_cnt_d = 32'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: ;
        endcase

        if (load) begin
            hold_full_d = accept;
            shift_d     = hold_data_q;
            div_d       = div_eff;
            baud_cnt_d  = div_eff - 32'd1;
            bit_cnt_d   = 4'd0;
            pin_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d       = (^hold_data_q) ^ (PARITY_ODD != 0);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            shift_q     <= '0;
            div_q       <= 32'd1;
            baud_cnt_q  <= 32'd0;
            bit_cnt_q   <= 4'd0;
            pin_q       <= 1'b1;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            pin_q       <= pin_d;
            done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (second instance built with STOP_BITS=2)
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int PARITY_ODD = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] baud_div;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_pin, tx_busy, tx_done;
    logic        tx_valid2, tx_ready2, tx_pin2, tx_busy2, tx_done2;

    int checks = 0;
    int errors = 0;

    logic cap_pin[256], cap_ready[256], cap_busy[256], cap_done[256];
    logic cap_pin2[256], cap_done2[256];

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PARITY_ODD)) u_dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_pin(tx_pin),
        .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(PARITY_ODD)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_data(tx_data),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_pin(tx_pin2),
        .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int frame_len(input int nstop);
        return 1 + 8 + PAR + nstop;
    endfunction

    // Line levels of one frame, bit 0 = start bit.
    function automatic logic [11:0] frame_bits(input logic [7:0] b);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
        if (PAR == 1) f[9] = (^b) ^ (PARITY_ODD != 0);
        return f;
    endfunction

    // Sample both instances on falling edges; index 0 is the cycle after the handshake edge.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_pin[i]   = tx_pin;
            cap_ready[i] = tx_ready;
            cap_busy[i]  = tx_busy;
            cap_done[i]  = tx_done;
            cap_pin2[i]  = tx_pin2;
            cap_done2[i] = tx_done2;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit second);
        int n = 0;
        @(negedge clk);
        while (((second ? tx_ready2 : tx_ready) !== 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if ((second ? tx_ready2 : tx_ready) !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout: tx_ready never rose for byte %h", b);
        end
        tx_data = b;
        if (second) tx_valid2 = 1'b1; else tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    task automatic test_reset;
        int bad = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_pin !== 1'b1)   begin errors++; $display("FAIL reset_pin got %b want 1", tx_pin); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        checks++; if (tx_done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_pin2 !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_idle_activity got %0d active cycles want 0", bad); end
    endtask

    task automatic test_single_byte;
        int d = 4;
        int f = frame_len(1);
        logic [11:0] fb = frame_bits(8'hA5);
        int ndone = 0;
        baud_div = 32'd4;
        send(8'hA5, 1'b0);
        fork
            capture(1 + f*d + 3);
            begin repeat (5) @(negedge clk); baud_div = 32'd9; end
        join
        checks++; if (cap_pin[0] !== 1'b1)   begin errors++; $display("FAIL single_pre_start pin got %b want 1", cap_pin[0]); end
        checks++; if (cap_ready[0] !== 1'b0) begin errors++; $display("FAIL single_ready_full got %b want 0", cap_ready[0]); end
        checks++; if (cap_ready[1] !== 1'b1) begin errors++; $display("FAIL single_ready_freed got %b want 1", cap_ready[1]); end
        checks++; if (cap_busy[1] !== 1'b1)  begin errors++; $display("FAIL single_busy got %b want 1", cap_busy[1]); end
        for (int i = 0; i < f*d; i++) begin
            checks++;
            if (cap_pin[1+i] !== fb[i/d]) begin
                errors++; $display("FAIL single_line[%0d] got %b want %b", i, cap_pin[1+i], fb[i/d]);
            end
        end
        for (int i = 0; i < 1 + f*d + 3; i++) if (cap_done[i] === 1'b1) ndone++;
        checks++; if (ndone != 1) begin errors++; $display("FAIL single_done_count got %0d want 1", ndone); end
        checks++; if (cap_done[1+f*d] !== 1'b1) begin errors++; $display("FAIL single_done_pos got %b want 1", cap_done[1+f*d]); end
        checks++; if (cap_busy[1+f*d] !== 1'b0) begin errors++; $display("FAIL single_busy_drop got %b want 0", cap_busy[1+f*d]); end
        baud_div = 32'd4;
    endtask

    task automatic test_back_to_back;
        int d = 3;
        int f = frame_len(1);
        logic [11:0] fa = frame_bits(8'h00);
        logic [11:0] fz = frame_bits(8'hFF);
        int ndone = 0;
        int gaps = 0;
        @(negedge clk);
        baud_div = 32'd3;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'hFF;
        fork
            capture(1 + 2*f*d + 3);
            begin @(posedge clk); @(posedge clk); #1 tx_valid = 1'b0; end
        join
        checks++; if (cap_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_load got %b want 1", cap_ready[1]); end
        checks++; if (cap_ready[2] !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_accept got %b want 0", cap_ready[2]); end
        checks++; if (cap_ready[f*d] !== 1'b0) begin errors++; $display("FAIL b2b_ready_held got %b want 0", cap_ready[f*d]); end
        for (int i = 0; i < f*d; i++) begin
            checks++;
            if (cap_pin[1+i] !== fa[i/d] || cap_pin[1+f*d+i] !== fz[i/d]) begin
                errors++; $display("FAIL b2b_line[%0d] got %b/%b want %b/%b", i, cap_pin[1+i], cap_pin[1+f*d+i], fa[i/d], fz[i/d]);
            end
        end
        for (int i = 1; i <= 2*f*d; i++) if (cap_busy[i] !== 1'b1) gaps++;
        checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_idle_gap got %0d idle cycles want 0", gaps); end
        for (int i = 0; i < 1 + 2*f*d + 3; i++) if (cap_done[i] === 1'b1) ndone++;
        checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
        checks++;
        if (cap_done[1+f*d] !== 1'b1 || cap_done[1+2*f*d] !== 1'b1) begin
            errors++; $display("FAIL b2b_done_spacing got %b,%b want 1,1", cap_done[1+f*d], cap_done[1+2*f*d]);
        end
    endtask

    task automatic test_edge_divisors;
        int f = frame_len(1);
        int f2 = frame_len(2);
        logic [11:0] fb = frame_bits(8'h3C);
        for (int k = 0; k < 2; k++) begin
            baud_div = k;
            send(8'h3C, 1'b0);
            capture(1 + f + 3);
            for (int i = 0; i < f; i++) begin
                checks++;
                if (cap_pin[1+i] !== fb[i]) begin
                    errors++; $display("FAIL div%0d_line[%0d] got %b want %b", k, i, cap_pin[1+i], fb[i]);
                end
            end
            checks++;
            if (cap_done[f] !== 1'b0 || cap_done[1+f] !== 1'b1 || cap_done[2+f] !== 1'b0) begin
                errors++; $display("FAIL div%0d_done got %b%b%b want 010", k, cap_done[f], cap_done[1+f], cap_done[2+f]);
            end
        end
        baud_div = 32'd2;
        send(8'h3C, 1'b1);
        capture(1 + f2*2 + 3);
        for (int i = 0; i < f2*2; i++) begin
            checks++;
            if (cap_pin2[1+i] !== fb[i/2]) begin
                errors++; $display("FAIL stop2_line[%0d] got %b want %b", i, cap_pin2[1+i], fb[i/2]);
            end
        end
        checks++;
        if (cap_done2[f2*2] !== 1'b0 || cap_done2[1+f2*2] !== 1'b1) begin
            errors++; $display("FAIL stop2_done got %b%b want 01", cap_done2[f2*2], cap_done2[1+f2*2]);
        end
    endtask

    task automatic test_parity;
`ifdef UART_TX_PARITY_EN
        int f = frame_len(1);
        baud_div = 32'd2;
        send(8'h07, 1'b0);
        capture(1 + f*2 + 3);
        checks++; if (cap_pin[1+18] !== 1'b1 || cap_pin[2+18] !== 1'b1) begin errors++; $display("FAIL parity_07 got %b want 1", cap_pin[1+18]); end
        checks++; if (cap_done[1+22] !== 1'b1) begin errors++; $display("FAIL parity_frame22 done got %b want 1", cap_done[1+22]); end
        send(8'h03, 1'b0);
        capture(1 + f*2 + 3);
        checks++; if (cap_pin[1+18] !== 1'b0 || cap_pin[2+18] !== 1'b0) begin errors++; $display("FAIL parity_03 got %b want 0", cap_pin[1+18]); end
`endif
    endtask

    task automatic test_reset_mid_frame;
        int f = frame_len(1);
        logic [11:0] fb = frame_bits(8'hC3);
        int bad = 0;
        int ndone = 0;
        baud_div = 32'd8;
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        repeat (17) @(negedge clk);
        checks++; if (tx_pin !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL midrst_pre pin/ready got %b/%b want 0/0", tx_pin, tx_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_pin !== 1'b1)   begin errors++; $display("FAIL midrst_pin got %b want 1", tx_pin); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin errors++; $display("FAIL midrst_busy_done got %b/%b want 0/0", tx_busy, tx_done); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_discard got %0d active cycles want 0", bad); end
        baud_div = 32'd2;
        send(8'hC3, 1'b0);
        capture(1 + f*2 + 30);
        for (int i = 0; i < f*2; i++) begin
            checks++;
            if (cap_pin[1+i] !== fb[i/2]) begin
                errors++; $display("FAIL midrst_new_line[%0d] got %b want %b", i, cap_pin[1+i], fb[i/2]);
            end
        end
        bad = 0;
        for (int i = 2 + f*2; i < 1 + f*2 + 30; i++) if (cap_pin[i] !== 1'b1 || cap_busy[i] !== 1'b0) bad++;
        for (int i = 0; i < 1 + f*2 + 30; i++) if (cap_done[i] === 1'b1) ndone++;
        checks++; if (bad != 0 || ndone != 1) begin errors++; $display("FAIL midrst_single_frame got %0d trailing active, %0d dones want 0, 1", bad, ndone); end
    endtask

    initial begin
        rst_n     = 1'b0;
        baud_div  = 32'd4;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        test_reset;
        test_single_byte;
        repeat (5) @(negedge clk);
        test_back_to_back;
        repeat (5) @(negedge clk);
        test_edge_divisors;
        repeat (5) @(negedge clk);
        test_parity;
        repeat (5) @(negedge clk);
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
